// File: rtl/normalizer.sv
// Iterative normalizer: shifts an operand left one bit per cycle until its
// leading bit (logical) or sign boundary (signed) reaches bit 15.
module normalizer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       off,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [3:0]       count;
  logic             mode;
  logic             zero_acc;
  logic [WIDTH-1:0] y_q;
  logic [3:0]       off_q;
  logic             zero_q;
  logic             stop;

  // Result registers are separate from the working register so the visible
  // outputs hold their last values while a new operand is being scanned.
  always_comb begin
    stop = 1'b0;
    if (count == 4'd15)
      stop = 1'b1;
    else if (mode)
      stop = work[WIDTH-1] ^ work[WIDTH-2];
    else
      stop = work[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      work     <= '0;
      count    <= '0;
      mode     <= 1'b0;
      zero_acc <= 1'b0;
      y_q      <= '0;
      off_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= x;
            count    <= '0;
            mode     <= arith;
            zero_acc <= (x == '0);
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (stop) begin
            y_q    <= work;
            off_q  <= count;
            zero_q <= zero_acc;
            state  <= DONE;
          end else begin
            work  <= {work[WIDTH-2:0], 1'b0};
            count <= count + 4'd1;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y         = y_q;
  assign off       = off_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Self-checking bench for normalizer: directed vector table, hand-written
// backpressure/reset sequences, and randomized operands against a reference model.
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic [3:0]  off;
  logic        zero;

  int tests = 0;
  int fails = 0;

  normalizer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .off       (off),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic        a;
    logic [15:0] y;
    logic [3:0]  off;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Normalization as leading-bit counting: logical counts leading zeros,
  // signed counts bits below the sign that repeat it; both capped at 15.
  function automatic void model(input logic [15:0] xv, input logic a,
                                output logic [15:0] ym, output logic [3:0] om,
                                output logic zm);
    int k;
    bit run;
    k = 0;
    run = 1'b1;
    if (a) begin
      for (int i = 14; i >= 0; i--) begin
        if (run && xv[i] == xv[15]) k++;
        else run = 1'b0;
      end
    end else begin
      for (int i = 15; i >= 0; i--) begin
        if (run && !xv[i]) k++;
        else run = 1'b0;
      end
    end
    if (k > 15) k = 15;
    om = 4'(k);
    ym = xv << k;
    zm = (xv == 16'h0000);
  endfunction

  // Issue one operand from IDLE; lat counts edges from the accept edge
  // (inclusive) to the edge after which out_valid is seen high.
  task automatic do_op(input logic [15:0] xi, input logic ai, input int hold,
                       output logic [15:0] yo, output logic [3:0] oo,
                       output logic zo, output int lat);
    in_valid = 1'b1;
    x = xi;
    arith = ai;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    x = 16'($urandom);
    arith = 1'($urandom);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    yo = y;
    oo = off;
    zo = zero;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ry, my, rt, cap_y;
    logic [3:0]  ro, mo, cap_o;
    logic        rz, mz, cap_z;
    logic signed [15:0] sy;
    int lat;
    logic [15:0] rx;
    logic ra;

    vecs[0] = '{x: 16'h8000, a: 1'b0, y: 16'h8000, off: 4'd0,  z: 1'b0};
    vecs[1] = '{x: 16'h0001, a: 1'b0, y: 16'h8000, off: 4'd15, z: 1'b0};
    vecs[2] = '{x: 16'h0000, a: 1'b0, y: 16'h0000, off: 4'd15, z: 1'b1};
    vecs[3] = '{x: 16'h0000, a: 1'b1, y: 16'h0000, off: 4'd15, z: 1'b1};
    vecs[4] = '{x: 16'hFFF0, a: 1'b1, y: 16'h8000, off: 4'd11, z: 1'b0};
    vecs[5] = '{x: 16'h0003, a: 1'b1, y: 16'h6000, off: 4'd13, z: 1'b0};
    vecs[6] = '{x: 16'hFFFF, a: 1'b1, y: 16'h8000, off: 4'd15, z: 1'b0};
    vecs[7] = '{x: 16'hFFFF, a: 1'b0, y: 16'hFFFF, off: 4'd0,  z: 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    arith = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'h0);
    check("rst_off", 32'(off), 32'h0);
    check("rst_zero", 32'(zero), 32'h0);
    rst = 1'b0;

    // First vector is accepted on the first edge after reset release.
    foreach (vecs[i]) begin
      do_op(vecs[i].x, vecs[i].a, i % 3, ry, ro, rz, lat);
      check($sformatf("vec%0d_y", i), 32'(ry), 32'(vecs[i].y));
      check($sformatf("vec%0d_off", i), 32'(ro), 32'(vecs[i].off));
      check($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].z));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].off) + 32'd2);
    end

    // Backpressure: result held, no second accept while DONE.
    in_valid = 1'b1;
    x = 16'h0100;
    arith = 1'b0;
    @(posedge clk); #1;
    x = 16'h0001;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    cap_y = y; cap_o = off; cap_z = zero;
    check("bp_y", 32'(cap_y), 32'h8000);
    check("bp_off", 32'(cap_o), 32'd7);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_y", 32'(y), 32'(cap_y));
      check("bp_hold_off", 32'(off), 32'(cap_o));
      check("bp_hold_zero", 32'(zero), 32'(cap_z));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_no_second_accept", 32'(in_ready), 32'd1);

    // Reset four edges after accept aborts the scan.
    in_valid = 1'b1;
    x = 16'h0001;
    arith = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_y", 32'(y), 32'h0);
    check("abort_off", 32'(off), 32'h0);
    do_op(16'h4000, 1'b0, 0, ry, ro, rz, lat);
    check("after_abort_y", 32'(ry), 32'h8000);
    check("after_abort_off", 32'(ro), 32'd1);
    check("after_abort_lat", 32'(lat), 32'd3);

    // Randomized round-trip against the model.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: rx = 16'($urandom);
        1: rx = 16'($urandom) >> $urandom_range(0, 15);
        2: rx = ~(16'($urandom) >> $urandom_range(0, 15));
        default: rx = 16'(1) << $urandom_range(0, 15);
      endcase
      ra = 1'($urandom);
      model(rx, ra, my, mo, mz);
      do_op(rx, ra, $urandom_range(0, 2), ry, ro, rz, lat);
      check("rand_y", 32'(ry), 32'(my));
      check("rand_off", 32'(ro), 32'(mo));
      check("rand_zero", 32'(rz), 32'(mz));
      check("rand_lat", 32'(lat), 32'(mo) + 32'd2);
      sy = ry;
      rt = ra ? 16'(sy >>> ro) : (ry >> ro);
      check("rand_roundtrip", 32'(rt), 32'(rx));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/normalizer.md
NORMALIZER -- requirements
Module: normalizer

Interface
REQ-001 Parameter: WIDTH, 16, data width; fixed at 16; shift-count width is 4.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand request.
REQ-005 Port: in_ready  output  1  block can accept an operand.
REQ-006 Port: x  input  16  operand, sampled on accept.
REQ-007 Port: arith  input  1  0 = logical normalize, 1 = signed normalize; sampled on accept.
REQ-008 Port: out_valid  output  1  result available.
REQ-009 Port: out_ready  input  1  consumer takes result.
REQ-010 Port: y  output  16  normalized word.
REQ-011 Port: off  output  4  left-shift count applied to x.
REQ-012 Port: zero  output  1  sampled x was 0x0000.

Function
REQ-013 The block is the inverse of the ALU shifter: it computes off such that a right shift of y by off recovers x (logical right shift for arith=0, arithmetic right shift for arith=1).
REQ-014 The FSM shall have three states: IDLE, SCAN and DONE.
REQ-015 In IDLE, in_ready=1 and out_valid=0.
REQ-016 In SCAN and DONE, in_ready=0, and in_valid is ignored.
REQ-017 Accept occurs on any edge in IDLE with in_valid=1.
REQ-018 On accept, the block loads the working register with x, count with 0, the mode with arith and zero with (x==0), then enters SCAN.
REQ-019 Stop condition, arith=0: register bit 15 = 1.
REQ-020 Stop condition, arith=1: register bit 15 differs from register bit 14.
REQ-021 Stop condition, both modes: count = 15.
REQ-022 On each SCAN edge, if the stop condition holds on the current register the block enters DONE; otherwise it shifts the register left by 1 (zero fill into bit 0) and increments count by 1.
REQ-023 At most one shift shall occur per cycle; count shall never wrap past 15.
REQ-024 Latency: out_valid shall rise exactly off+2 edges after the accept edge (1 load edge, off shift edges, 1 stop edge).
REQ-025 In DONE, out_valid=1, and y, off and zero are driven from registers and held stable until handshake completion.
REQ-026 The DONE to IDLE transition occurs on an edge where out_ready=1; an operand cannot be accepted on that same edge (in_ready=0 in DONE).
REQ-027 Outside DONE, y, off and zero shall hold their last values; they are don't-care while out_valid=0.
REQ-028 Input x=0x0000 in either mode: y=0x0000, off=15, zero=1.
REQ-029 Input x=0xFFFF with arith=1: y=0x8000, off=15, zero=0.
REQ-030 Input x=0xFFFF with arith=0: y=0xFFFF, off=0.
REQ-031 A change of arith or x after accept shall not affect the operation in flight.
REQ-032 The block shall be purely synchronous, with no combinational path from in_valid or out_ready to any output.

Reset
REQ-033 While rst=1 on an edge, the state shall become IDLE and count 0, with outputs in_ready=1, out_valid=0, y=0x0000, off=0, zero=0.
REQ-034 rst shall take priority over every handshake and over any SCAN or DONE activity, aborting the operation in flight with no result emitted.
REQ-035 The first accept is possible on the first edge after rst deasserts.

Verification
REQ-036 Logical, minimum shift: arith=0, x=0x8000 -> y=0x8000, off=0, zero=0, out_valid 2 edges after accept.
REQ-037 Logical, maximum shift: arith=0, x=0x0001 -> y=0x8000, off=15, zero=0, out_valid 17 edges after accept.
REQ-038 Zero input: arith=0 and arith=1, x=0x0000 -> y=0x0000, off=15, zero=1.
REQ-039 Signed normalize: arith=1, x=0xFFF0 -> y=0x8000, off=11; and arith=1, x=0x0003 -> y=0x6000, off=13.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 throughout -> y/off/zero stable, in_ready=0, no second accept; IDLE is reached 1 edge after out_ready=1.
REQ-041 Reset mid-SCAN: arith=0, x=0x0001, assert rst 4 edges after accept -> in_ready=1 and out_valid=0 on the next edge; a new operand x=0x4000 then yields off=1, y=0x8000.
REQ-042 Randomized round-trip: right shift of y by off shall equal x for every x and arith.
